// File: rtl/div_32.sv
// div_32 -- iterative radix-2 restoring divider, one quotient bit per clock.
// start/busy/done handshake; Q, R and div_by_zero hold until the next accepted start.
// Optional build macro DIV_SIGNED_EN: two's complement operands, with quotient
// truncated toward zero and remainder taking the sign of the dividend.
module div_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;   // partial remainder
  logic [WIDTH-1:0] quo;   // dividend bits shift out of the top, quotient bits enter at the bottom
  logic [WIDTH-1:0] dvs;   // divisor (magnitude in the signed build)

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Operand magnitudes, and sign fix-up of the final unsigned result
  always_comb begin
    a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
    b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;
    q_fin = neg_q ? (~quo_nx + 1'b1) : quo_nx;
    r_fin = neg_r ? (~rem_nx + 1'b1) : rem_nx;
  end
`else
  // Unsigned build: operands and results pass straight through
  always_comb begin
    a_mag = A;
    b_mag = B;
    q_fin = quo_nx;
    r_fin = rem_nx;
  end
`endif

  // One restoring step: rem < dvs always holds, so the WIDTH+1-bit trial's
  // top bit is its sign and a restored remainder always fits in WIDTH bits.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs};
    if (!trial[WIDTH]) begin
      rem_nx = trial[WIDTH-1:0];
    end else begin
      rem_nx = rem_sh[WIDTH-1:0];
    end
    quo_nx = {quo[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Control FSM with registered handshake outputs and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      Q           <= '0;
      R           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (B == '0) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              Q           <= '1;
              R           <= A;
              div_by_zero <= 1'b1;
            end else begin
              state       <= ST_RUN;
              rem         <= '0;
              cnt         <= '0;
              quo         <= a_mag;
              dvs         <= b_mag;
              div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
              neg_q       <= A[WIDTH-1] ^ B[WIDTH-1];
              neg_r       <= A[WIDTH-1];
`endif
            end
          end
        end
        ST_RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            Q     <= q_fin;
            R     <= r_fin;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_32.sv
// tb_div_32 -- self-checking bench for div_32: directed cases plus randomized
// operands against an arithmetic reference model. Honours DIV_SIGNED_EN.
module tb_div_32;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         dbz;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  div_32 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .A          (A),
    .B          (B),
    .Q          (Q),
    .R          (R),
    .busy       (busy),
    .done       (done),
    .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic on the operands
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    int sa;
    int sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Run one division from an IDLE cycle; optionally fire ignored starts mid-run
  // and in the DONE cycle. Returns in the IDLE cycle after DONE.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int unsigned  n;
    int unsigned  lat;
    ref_div(a, b, eq, er, ez);
    lat   = (b == 0) ? 0 : W;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    check("busy_after_accept", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < W + 8) begin
      if (disturb && (n == 10 || n == W - 1)) begin
        start = 1'b1;
        A     = 50;
        B     = 5;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check("latency", n, lat);
    check("Q", Q, eq);
    check("R", R, er);
    check("div_by_zero", 32'(dbz), 32'(ez));
    if (disturb) begin
      start = 1'b1;
      A     = 50;
      B     = 5;
    end
    tick();
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_back_idle", 32'(busy), 32'd0);
    check("Q_held", Q, eq);
    check("R_held", R, er);
  endtask

  initial begin
    int unsigned seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    tick();
    tick();
    check("rst_Q", Q, '0);
    check("rst_R", R, '0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dbz", 32'(dbz), 32'd0);
    rst = 1'b0;
    tick();

    do_div(32'd100, 32'd7, 1'b0);
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    do_div(32'd5, 32'd9, 1'b0);
    do_div(32'h1234, 32'd0, 1'b0);
    do_div(32'd20, 32'd4, 1'b0);
    do_div(32'h1234, 32'd0, 1'b1);
    do_div(32'd100, 32'd7, 1'b1);
    do_div(32'd50, 32'd5, 1'b0);

    // Reset in the middle of a running division
    A     = 32'd1000;
    B     = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    rst = 1'b1;
    #1;
    check("midrst_Q", Q, '0);
    check("midrst_R", R, '0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < int'(W) + 8; i++) begin
      tick();
      if (done) seen++;
    end
    check("no_done_after_rst", seen, 0);
    do_div(32'd9, 32'd4, 1'b0);

`ifdef DIV_SIGNED_EN
    do_div(-32'sd7, 32'd2, 1'b0);
    do_div(32'd7, -32'sd2, 1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_div(-32'sd100, -32'sd7, 1'b0);
    do_div(32'h8000_0000, 32'd0, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 255);
        2:       rb = (i % 5 == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      do_div(ra, rb, ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
